// File: rtl/divider.sv
// 32-bit iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIVIDER_EARLY_OUT_EN short-circuits divide-by-zero and signed overflow.
module divider (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic [31:0] op_1_i,
    input  logic [31:0] op_2_i,
    input  logic        is_signed_i,
    input  logic        result_rem_i,
    output logic [31:0] result_o,
    output logic        ack_o
);

    typedef enum logic [1:0] {StIdle, StDiv, StFixup, StDone} state_e;

    state_e      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_rem_sel;
    logic        r_neg_quo;
    logic        r_neg_rem;
    logic [31:0] r_result;
    logic        r_ack;

    logic        w_dividend_neg;
    logic        w_divisor_neg;
    logic [31:0] w_dividend_mag;
    logic [31:0] w_divisor_mag;
    logic [32:0] w_shift;
    logic [31:0] w_diff;
    logic        w_ge;

    assign w_dividend_neg = is_signed_i & op_1_i[31];
    assign w_divisor_neg  = is_signed_i & op_2_i[31];
    assign w_dividend_mag = w_dividend_neg ? (~op_1_i + 32'd1) : op_1_i;
    assign w_divisor_mag  = w_divisor_neg  ? (~op_2_i + 32'd1) : op_2_i;

    // The quotient register doubles as the dividend shift source.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = w_shift[31:0] - r_divisor;

`ifdef DIVIDER_EARLY_OUT_EN
    logic w_div_zero;
    logic w_overflow;

    assign w_div_zero = (op_2_i == 32'd0);
    assign w_overflow = is_signed_i && (op_1_i == 32'h8000_0000) && (op_2_i == 32'hFFFF_FFFF);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= StIdle;
            r_count   <= 5'd0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_rem_sel <= 1'b0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= 32'd0;
            r_ack     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_ack <= 1'b0;
                    if (stb_i) begin
                        r_count   <= 5'd0;
                        r_rem     <= 32'd0;
                        r_quo     <= w_dividend_mag;
                        r_divisor <= w_divisor_mag;
                        r_rem_sel <= result_rem_i;
                        r_neg_quo <= (w_dividend_neg ^ w_divisor_neg) && (op_2_i != 32'd0);
                        r_neg_rem <= w_dividend_neg;
                        r_state   <= StDiv;
`ifdef DIVIDER_EARLY_OUT_EN
                        // Later assignments override the iterative setup above.
                        if (w_div_zero) begin
                            r_quo   <= 32'hFFFF_FFFF;
                            r_rem   <= op_1_i;
                            r_state <= StDone;
                        end else if (w_overflow) begin
                            r_quo   <= 32'h8000_0000;
                            r_rem   <= 32'd0;
                            r_state <= StDone;
                        end
`endif
                    end
                end
                StDiv: begin
                    r_rem   <= w_ge ? w_diff : w_shift[31:0];
                    r_quo   <= {r_quo[30:0], w_ge};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= StFixup;
                    end
                end
                StFixup: begin
                    if (r_neg_quo) begin
                        r_quo <= ~r_quo + 32'd1;
                    end
                    if (r_neg_rem) begin
                        r_rem <= ~r_rem + 32'd1;
                    end
                    r_state <= StDone;
                end
                StDone: begin
                    r_result <= r_rem_sel ? r_rem : r_quo;
                    r_ack    <= 1'b1;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ack_o    = r_ack;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: spec vectors, random ops vs an arithmetic model,
// mid-operation reset and back-to-back strobes.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic        is_signed;
    logic        result_rem;
    logic [31:0] result;
    logic        ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .stb_i        (stb),
        .op_1_i       (op_1),
        .op_2_i       (op_2),
        .is_signed_i  (is_signed),
        .result_rem_i (result_rem),
        .result_o     (result),
        .ack_o        (ack)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        rs;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference semantics from plain integer arithmetic plus the two special cases.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic rs);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return rs ? r : q;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIVIDER_EARLY_OUT_EN
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 34;
    endfunction

    // One transaction; inputs are scrambled while busy to prove they are ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic rs, output logic [31:0] res, output int lat,
                          output logic ack_next);
        @(negedge clk);
        op_1 = a; op_2 = b; is_signed = s; result_rem = rs; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        op_1 = $urandom; op_2 = $urandom;
        is_signed = 1'($urandom); result_rem = 1'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack) break;
            stb = (lat < 30) ? 1'($urandom) : 1'b0;
        end
        stb = 1'b0;
        res = result;
        @(posedge clk);
        #1;
        ack_next = ack;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic        ack_next;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        rs;
        int          lat;
        int          seen;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14};
        vecs[1]  = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD};
        vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[4]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD};
        vecs[5]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1};
        vecs[6]  = '{32'h8765_4321,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[7]  = '{32'h8765_4321,  32'd0,          1'b1, 1'b1, 32'h8765_4321};
        vecs[8]  = '{32'h8765_4321,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h8765_4321,  32'd0,          1'b0, 1'b1, 32'h8765_4321};
        vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000};
        vecs[11] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0};
        vecs[12] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0};
        vecs[13] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000};

        rst_n = 1'b0; stb = 1'b0; op_1 = '0; op_2 = '0; is_signed = 1'b0; result_rem = 1'b0;
        #12;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].rs, res, lat, ack_next);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(ref_lat(vecs[i].a, vecs[i].b, vecs[i].s)));
            check($sformatf("vec%0d_ack_pulse", i), 32'(ack_next), 32'd0);
            check($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom;
            s = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            run_op(a, b, s, rs, res, lat, ack_next);
            check($sformatf("rand%0d_result", i), res, ref_div(a, b, s, rs));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(a, b, s)));
        end

        // Abort at DIV count 10; result holds 14 beforehand so the async clear is visible.
        run_op(32'd100, 32'd7, 1'b0, 1'b0, res, lat, ack_next);
        check("pre_abort_result", res, 32'd14);
        @(negedge clk);
        op_1 = 32'd100; op_2 = 32'd7; is_signed = 1'b0; result_rem = 1'b0; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_result", result, 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (ack) seen++;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 1'b0, res, lat, ack_next);
        check("after_abort_result", res, 32'd14);
        check("after_abort_latency", 32'(lat), 32'd34);

        // Strobe sampled on the very first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op_1 = 32'd100; op_2 = 32'd7; is_signed = 1'b0; result_rem = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack) break;
        end
        check("first_edge_result", result, 32'd2);
        check("first_edge_latency", 32'(lat), 32'd34);

        // stb held high: a new operand set is presented right after each ack.
        @(negedge clk);
        a = $urandom; b = $urandom | 32'd1; s = 1'($urandom); rs = 1'($urandom);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
        op_1 = a; op_2 = b; is_signed = s; result_rem = rs; stb = 1'b1;
        exp = ref_div(a, b, s, rs);
        @(posedge clk);
        for (int t = 0; t < 6; t++) begin
            lat = 0;
            while (lat < 100) begin
                @(posedge clk);
                lat++;
                #1;
                if (ack) break;
            end
            check($sformatf("b2b%0d_result", t), result, exp);
            check($sformatf("b2b%0d_spacing", t), 32'(lat), (t == 0) ? 32'd34 : 32'd35);
            a = $urandom; b = $urandom | 32'd1; s = 1'($urandom); rs = 1'($urandom);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            op_1 = a; op_2 = b; is_signed = s; result_rem = rs;
            exp = ref_div(a, b, s, rs);
            if (t == 5) stb = 1'b0;
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ack) seen++;
        end
        check("b2b_no_extra_ack", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port stb_i, input, 1: starts a transaction when sampled high in IDLE.
REQ-005 SHALL have port op_1_i, input, 32: dividend.
REQ-006 SHALL have port op_2_i, input, 32: divisor.
REQ-007 SHALL have port is_signed_i, input, 1: 1 selects DIV/REM (two's complement), 0 selects DIVU/REMU.
REQ-008 SHALL have port result_rem_i, input, 1: 1 returns the remainder, 0 returns the quotient.
REQ-009 SHALL have port result_o, output, 32: quotient or remainder, held until the next completion.
REQ-010 SHALL have port ack_o, output, 1: one-cycle completion pulse, asserted when result_o is valid.

Function
REQ-011 SHALL implement states IDLE, DIV, FIXUP and DONE.
REQ-012 IDLE SHALL drive ack_o low; on stb_i high it SHALL capture all inputs, |dividend|, |divisor| (magnitude only when is_signed_i), sign flags, remainder=0 and count=0, then go to DIV.
REQ-013 stb_i and input changes outside IDLE SHALL be ignored; the captured copies SHALL be used throughout.
REQ-014 DIV SHALL perform one restoring step per cycle: shift {rem, quo} left 1; if the 33-bit shifted remainder >= divisor, subtract and set quotient LSB to 1.
REQ-015 DIV SHALL run exactly 32 cycles; count SHALL wrap from 31 to 0, and the state SHALL go to FIXUP on count 31.
REQ-016 FIXUP SHALL negate the quotient iff signed, the operand signs differ and divisor != 0; it SHALL negate the remainder iff signed and the dividend is negative; then go to DONE.
REQ-017 DONE SHALL load result_o (remainder if result_rem_i else quotient), set ack_o=1 and return to IDLE.
REQ-018 Latency SHALL be: stb_i sampled at edge N, ack_o set at edge N+34, and ack_o high for exactly one cycle.
REQ-019 A stb_i sampled high while ack_o=1 SHALL start a new transaction, giving back-to-back acks 35 edges apart.
REQ-020 Divide-by-zero SHALL yield quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient 0x80000000 and remainder 0.

Reset
REQ-022 rst_n_i low SHALL immediately force state IDLE, ack_o=0, result_o=0 and count=0, regardless of the clock.
REQ-023 Reset during DIV, FIXUP or DONE SHALL abort the operation, and no ack_o SHALL be produced for it.
REQ-024 The first rising edge after rst_n_i deasserts SHALL be able to sample stb_i.

Configuration
REQ-025 Macro DIVIDER_EARLY_OUT_EN, when defined, SHALL make IDLE route divide-by-zero and signed overflow directly to DONE with the REQ-020/021 results preloaded, so that ack_o is set at edge N+1.
REQ-026 Without DIVIDER_EARLY_OUT_EN, all operations SHALL take the 34-edge path, with the REQ-020/021 results produced by the iteration and fixup alone.

Verification
REQ-027 Unsigned: op_1=100, op_2=7 -> quotient 14, remainder 2, ack_o exactly 34 edges after the strobe.
REQ-028 Signed: op_1=0xFFFFFFF9 (-7), op_2=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-029 Divide-by-zero, signed and unsigned: op_1=0x87654321, op_2=0 -> quotient 0xFFFFFFFF, remainder 0x87654321; latency 34 edges without the macro, 1 edge with it.
REQ-030 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-031 rst_n_i pulsed low mid-cycle at DIV count 10 -> ack_o, result_o go 0 asynchronously, no ack follows; a subsequent 100/7 completes correctly.
REQ-032 stb_i held high with random operands -> acks every 35 edges, each result matching the reference model, no missed or duplicated acks.
